// File: rtl/uart_tx_ctrl.sv
// UART transmit framing controller: sequences start, data, parity and stop
// bits around an external serializer and drives the serial line.
module uart_tx_ctrl #(
  parameter int unsigned STOP_BITS = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic DATA_VALID,
  input  logic PAR_EN,
  input  logic ser_data,
  input  logic ser_done,
  input  logic par_bit,
  output logic ser_en,
  output logic TX_OUT,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  state_t state;
  state_t state_nx;
  logic   par_en_q;
  logic   stop_cnt;
  logic   last_stop;
  logic   take;

  assign last_stop = (state == STOP) && (stop_cnt == STOP_LAST);

  // A request is accepted only when idle or in the final stop cycle.
  assign take = DATA_VALID &&
                ((state == IDLE) || last_stop);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_en_q <= 1'b0;
    end else if (take) begin
      par_en_q <= PAR_EN;
    end
  end

  // Zero on STOP entry; advances through non-final stop cycles.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stop_cnt <= 1'b0;
    end else if (state == STOP && !last_stop) begin
      stop_cnt <= stop_cnt + 1'b1;
    end else begin
      stop_cnt <= 1'b0;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (take) state_nx = START;
      end
      START: state_nx = DATA;
      DATA: begin
        if (ser_done) begin
          state_nx = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: state_nx = STOP;
      STOP: begin
        if (last_stop) begin
          state_nx = take ? START : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    TX_OUT = 1'b1;
    ser_en = 1'b0;
    busy   = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
      end
      START: begin
        TX_OUT = 1'b0;
        ser_en = 1'b1;
      end
      DATA: begin
        TX_OUT = ser_data;
        ser_en = 1'b1;
      end
      PARITY: begin
        TX_OUT = par_bit;
      end
      STOP: begin
        TX_OUT = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: one instance per stop-bit setting,
// each paired with a small behavioural serializer.
module tb_uart_tx_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       dv = 1'b0;
  logic       pe = 1'b0;
  logic       sd_inj = 1'b0;
  logic [7:0] p_data = 8'h00;

  logic [1:0] tx;
  logic [1:0] sen;
  logic [1:0] bz;
  logic [1:0] sdat;
  logic [1:0] sdone;
  logic [1:0] spar;

  logic [3:0] scnt [2];
  logic [7:0] sbuf [2];

  logic [31:0] rt [2];
  logic [31:0] rb [2];
  logic [31:0] rs [2];

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  uart_tx_ctrl #(.STOP_BITS(1)) u_dut1 (
    .CLK        (CLK),
    .RST        (RST),
    .DATA_VALID (dv),
    .PAR_EN     (pe),
    .ser_data   (sdat[0]),
    .ser_done   (sdone[0]),
    .par_bit    (spar[0]),
    .ser_en     (sen[0]),
    .TX_OUT     (tx[0]),
    .busy       (bz[0])
  );

  uart_tx_ctrl #(.STOP_BITS(2)) u_dut2 (
    .CLK        (CLK),
    .RST        (RST),
    .DATA_VALID (dv),
    .PAR_EN     (pe),
    .ser_data   (sdat[1]),
    .ser_done   (sdone[1]),
    .par_bit    (spar[1]),
    .ser_en     (sen[1]),
    .TX_OUT     (tx[1]),
    .busy       (bz[1])
  );

  // Serializer: loads on the START edge, bit i in DATA cycle i+1.
  always @(posedge CLK or negedge RST) begin
    for (int k = 0; k < 2; k++) begin
      if (!RST) begin
        scnt[k] <= 4'd0;
        sbuf[k] <= 8'h00;
      end else if (sen[k]) begin
        if (scnt[k] == 4'd0) sbuf[k] <= p_data;
        scnt[k] <= (scnt[k] == 4'd8) ? 4'd0 : scnt[k] + 4'd1;
      end else begin
        scnt[k] <= 4'd0;
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_ser
    assign sdat[g]  = (scnt[g] != 4'd0) ?
                      sbuf[g][3'(scnt[g] - 4'd1)] : 1'b0;
    assign sdone[g] = (scnt[g] == 4'd8) | sd_inj;
    assign spar[g]  = ^sbuf[g];
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    for (int k = 0; k < 2; k++) begin
      rt[k] = '0;
      rb[k] = '0;
      rs[k] = '0;
    end
  endtask

  task automatic samp();
    for (int k = 0; k < 2; k++) begin
      rt[k] = {rt[k][30:0], tx[k]};
      rb[k] = {rb[k][30:0], bz[k]};
      rs[k] = {rs[k][30:0], sen[k]};
    end
  endtask

  task automatic rst_pulse();
    RST = 1'b0;
    dv  = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
  endtask

  initial begin
    clr();
    repeat (2) @(negedge CLK);
    chk("rst_d1", {29'd0, tx[0], sen[0], bz[0]}, 32'b100);
    chk("rst_d2", {29'd0, tx[1], sen[1], bz[1]}, 32'b100);
    RST = 1'b1;

    // A5 with even parity
    p_data = 8'hA5; pe = 1'b1; dv = 1'b1; clr();
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK); samp();
      if (i == 0) dv = 1'b0;
    end
    chk("a5_tx", rt[0][11:0], 32'b0101_0010_1011);
    chk("a5_busy", rb[0][11:0], 32'hFFE);
    chk("a5_seren", rs[0][11:0], 32'b1111_1111_1000);

    // 0F without parity, both stop settings
    rst_pulse();
    p_data = 8'h0F; pe = 1'b0; dv = 1'b1; clr();
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK); samp();
      if (i == 0) dv = 1'b0;
    end
    chk("0f_tx_s1", rt[0][11:0], 32'b0111_1000_0111);
    chk("0f_busy_s1", rb[0][11:0], 32'hFFC);
    chk("0f_tx_s2", rt[1][11:0], 32'b0111_1000_0111);
    chk("0f_busy_s2", rb[1][11:0], 32'hFFE);

    // back-to-back 01 then 80
    rst_pulse();
    p_data = 8'h01; pe = 1'b0; dv = 1'b1; clr();
    for (int i = 0; i < 21; i++) begin
      @(negedge CLK); samp();
      if (i == 5) p_data = 8'h80;
      if (i == 10) dv = 1'b0;
    end
    chk("b2b_tx", rt[0][20:0],
        {11'd0, 21'b0_1000_0000_10_0000_0001_11});
    chk("b2b_busy", rb[0][20:0], 32'h1FFFFE);

    // request during 4th data cycle is dropped
    rst_pulse();
    p_data = 8'h3C; pe = 1'b0; dv = 1'b1; clr();
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK); samp();
      if (i == 0) dv = 1'b0;
      if (i == 3) dv = 1'b1;
      if (i == 4) dv = 1'b0;
    end
    chk("ign_tx", rt[0][11:0], 32'b0001_1110_0111);
    chk("ign_busy", rb[0][11:0], 32'hFFC);

    // async reset in 5th data cycle
    rst_pulse();
    p_data = 8'h00; pe = 1'b1; dv = 1'b1; clr();
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (i == 0) dv = 1'b0;
    end
    chk("mid_pre", {29'd0, tx[0], sen[0], bz[0]}, 32'b011);
    #1 RST = 1'b0;
    #1;
    chk("mid_async_s1", {29'd0, tx[0], sen[0], bz[0]}, 32'b100);
    chk("mid_async_s2", {29'd0, tx[1], sen[1], bz[1]}, 32'b100);
    @(negedge CLK);
    RST = 1'b1; clr();
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK); samp();
    end
    chk("post_rst_tx", rt[0][3:0], 32'hF);
    chk("post_rst_busy", rb[0][3:0], 32'h0);

    // stray ser_done while idle
    sd_inj = 1'b1;
    @(negedge CLK);
    sd_inj = 1'b0;
    chk("idle_done", {31'd0, bz[0]}, 32'd0);

    // PAR_EN dropped mid-frame, stray ser_done in START/PARITY
    p_data = 8'hA5; pe = 1'b1; dv = 1'b1; clr();
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK); samp();
      if (i == 0) begin dv = 1'b0; sd_inj = 1'b1; end
      if (i == 1) sd_inj = 1'b0;
      if (i == 3) pe = 1'b0;
      if (i == 9) sd_inj = 1'b1;
      if (i == 10) sd_inj = 1'b0;
    end
    chk("pe_tog_tx", rt[0][11:0], 32'b0101_0010_1011);
    chk("pe_tog_busy", rb[0][11:0], 32'hFFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 The block SHALL have parameter STOP_BITS, default 1, legal 1 or 2: number of stop-bit cycles per frame.
REQ-002 CLK  input  1  bit-rate clock; all state changes on rising edge.
REQ-003 RST  input  1  asynchronous, active-low reset.
REQ-004 DATA_VALID  input  1  request to send one frame; upstream holds P_DATA stable in the same cycle.
REQ-005 PAR_EN  input  1  parity bit included in the frame when 1.
REQ-006 ser_data  input  1  current serial data bit from the serializer (registered there).
REQ-007 ser_done  input  1  serializer flag; high in the cycle ser_data carries bit 7.
REQ-008 par_bit  input  1  parity bit computed by the serializer.
REQ-009 ser_en  output  1  serializer enable.
REQ-010 TX_OUT  output  1  UART line, idle high.
REQ-011 busy  output  1  frame in progress.

Function
REQ-012 The block SHALL implement states IDLE, START, DATA, PARITY, STOP, held in a registered state variable.
REQ-013 In IDLE, DATA_VALID=1 SHALL move the FSM to START at the next edge and capture PAR_EN into an internal register par_en_q; otherwise it SHALL remain in IDLE.
REQ-014 START SHALL last exactly one cycle, then move to DATA.
REQ-015 DATA SHALL move to PARITY when ser_done=1 and par_en_q=1, to STOP when ser_done=1 and par_en_q=0, and otherwise remain in DATA (8 cycles with a compliant serializer).
REQ-016 PARITY SHALL last exactly one cycle, then move to STOP.
REQ-017 STOP SHALL last STOP_BITS cycles, counted by a stop counter cleared on STOP entry.
REQ-018 In the last STOP cycle, DATA_VALID=1 SHALL move the FSM directly to START and recapture PAR_EN; otherwise the FSM SHALL move to IDLE.
REQ-019 TX_OUT SHALL be a combinational function of state: IDLE 1, START 0, DATA ser_data, PARITY par_bit, STOP 1.
REQ-020 ser_en SHALL be 1 in START and DATA and 0 in all other states.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 DATA_VALID SHALL be ignored in START, DATA, PARITY, and in any non-final STOP cycle; no request is queued.
REQ-023 A PAR_EN change during a frame SHALL NOT affect that frame; only par_en_q is used.
REQ-024 Frame length SHALL be 1+8+P+STOP_BITS cycles, where P = par_en_q.
REQ-025 ser_done=1 outside DATA SHALL have no effect.

Reset
REQ-026 While RST=0, the state SHALL be IDLE, par_en_q 0, and the stop counter 0, giving TX_OUT=1, ser_en=0, busy=0.
REQ-027 RST asserted mid-frame SHALL force IDLE immediately (asynchronously); after release the FSM SHALL wait for a new DATA_VALID.
REQ-028 The first frame after reset release SHALL start no earlier than the first rising edge with RST=1 and DATA_VALID=1.

Verification
REQ-029 Reset, then DATA_VALID pulse with P_DATA=8'hA5, PAR_EN=1, even parity -> TX_OUT = 0,1,0,1,0,0,1,0,1,0,1 (start, LSB-first data, par 0, stop); busy high for 11 cycles.
REQ-030 P_DATA=8'h0F, PAR_EN=0, STOP_BITS=2 -> TX_OUT = 0,1,1,1,1,0,0,0,0,1,1 over 11 cycles; then idle 1, busy 0.
REQ-031 DATA_VALID held high continuously, two frames 8'h01 and 8'h80, PAR_EN=0 -> second start bit in the cycle immediately after the first frame's stop bit, with no idle gap.
REQ-032 DATA_VALID pulsed in the 4th DATA cycle -> ignored; exactly one frame sent; busy falls after its stop bit.
REQ-033 RST=0 during the 5th DATA cycle -> TX_OUT=1, ser_en=0, busy=0 without a clock edge; after release, with no DATA_VALID, the line stays 1.
REQ-034 PAR_EN toggled 1->0 during DATA of a PAR_EN=1 frame -> PARITY cycle still emitted; frame length 11.
